screen_interface2: RTL and testbench



---
 rtl/screen_interface2.sv | 159 +++++++++++++++
 tb/tb_screen_interface2.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/screen_interface2.sv
// Multi-bar status display: snapshots hp/maxhp in vertical blanking, computes the
// fill lengths with one shared restoring divider, then commits them all at once.
module screen_interface2 #(
  parameter int         CH       = 4,
  parameter int         HPW      = 8,
  parameter int         BAR_LEN  = 64,
  parameter int         BAR_H    = 8,
  parameter int         BAR_GAP  = 4,
  parameter int         X0       = 16,
  parameter int         Y0       = 16,
  parameter int         V_ACTIVE = 480,
  parameter int         CW       = 11,
  parameter logic [2:0] C_FULL   = 3'b010,
  parameter logic [2:0] C_LOW    = 3'b100,
  parameter logic [2:0] C_BORDER = 3'b111,
  parameter logic [2:0] C_BG     = 3'b001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     c1,
  input  logic [CW-1:0]     c2,
  input  logic [CH*HPW-1:0] hp,
  input  logic [CH*HPW-1:0] maxhp,
  output logic [2:0]        rgb,
  output logic              busy,
  output logic              update_done
);
  localparam int LB  = $clog2(BAR_LEN);
  localparam int NW  = HPW + LB;
  localparam int QW  = LB + 1;
  localparam int DCW = $clog2(NW + 1);

  generate
    if (CH < 1 || CH > 8) begin : g_bad_ch
      $error("CH must be 1..8");
    end
    if ((1 << LB) != BAR_LEN) begin : g_bad_len
      $error("BAR_LEN must be a power of two");
    end
    if (X0 + BAR_LEN + 1 >= (1 << CW) ||
        Y0 + CH * (BAR_H + BAR_GAP) - BAR_GAP - 1 >= (1 << CW)) begin : g_bad_geom
      $error("bar geometry does not fit in CW bits");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, COMMIT} state_t;

  state_t              state;
  logic [CH*HPW-1:0]   hp_s, mh_s;
  logic [2:0]          ch_idx;
  logic [NW-1:0]       quo;
  logic [HPW:0]        rem;
  logic [HPW-1:0]      den;
  logic [DCW-1:0]      div_cnt;
  logic [QW-1:0]       shadow_fill [CH];
  logic [QW-1:0]       active_fill [CH];

  logic [HPW-1:0] cur_hp, cur_mh, h_clamp;
  logic [HPW:0]   shifted;
  logic           take;

  assign cur_hp  = hp_s[ch_idx*HPW +: HPW];
  assign cur_mh  = mh_s[ch_idx*HPW +: HPW];
  assign h_clamp = (cur_hp > cur_mh) ? cur_mh : cur_hp;
  // rem < den always holds, so the shifted remainder fits in HPW+1 bits
  assign shifted = {rem[HPW-1:0], quo[NW-1]};
  assign take    = shifted >= {1'b0, den};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      update_done <= 1'b0;
      hp_s        <= '0;
      mh_s        <= '0;
      ch_idx      <= '0;
      quo         <= '0;
      rem         <= '0;
      den         <= '0;
      div_cnt     <= '0;
      for (int k = 0; k < CH; k++) begin
        shadow_fill[k] <= '0;
        active_fill[k] <= '0;
      end
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (c1 == '0 && c2 == CW'(V_ACTIVE)) begin
            hp_s   <= hp;
            mh_s   <= maxhp;
            ch_idx <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          quo     <= {h_clamp, LB'(0)};
          rem     <= '0;
          den     <= cur_mh;
          div_cnt <= '0;
          if (cur_mh == '0) begin
            quo   <= '0;
            state <= STORE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          rem     <= take ? (shifted - {1'b0, den}) : shifted;
          quo     <= {quo[NW-2:0], take};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DCW'(NW - 1)) state <= STORE;
        end
        STORE: begin
          shadow_fill[ch_idx] <= quo[QW-1:0];
          ch_idx              <= ch_idx + 1'b1;
          state               <= (ch_idx < 3'(CH - 1)) ? LOAD : COMMIT;
        end
        COMMIT: begin
          for (int k = 0; k < CH; k++) active_fill[k] <= shadow_fill[k];
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [CW-1:0] bar_top(input int k);
    return CW'(Y0 + k * (BAR_H + BAR_GAP));
  endfunction

  localparam logic [CW-1:0] XL = CW'(X0);
  localparam logic [CW-1:0] XR = CW'(X0 + BAR_LEN + 1);

  logic [CW-1:0] off;
  logic [2:0]    pix;
  assign off = c1 - CW'(X0 + 1);

  // Bars never overlap, so at most one iteration matches
  always_comb begin
    pix = 3'b000;
    for (int k = 0; k < CH; k++) begin
      if (c2 >= bar_top(k) && c2 <= bar_top(k) + CW'(BAR_H - 1) && c1 >= XL && c1 <= XR) begin
        if (c1 == XL || c1 == XR || c2 == bar_top(k) || c2 == bar_top(k) + CW'(BAR_H - 1))
          pix = C_BORDER;
        else if (off < CW'(active_fill[k]))
          pix = (active_fill[k] < QW'(BAR_LEN / 4)) ? C_LOW : C_FULL;
        else
          pix = C_BG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rgb <= 3'b000;
    else     rgb <= pix;
  end
endmodule

// File: tb/tb_screen_interface2.sv
// Directed bench for screen_interface2: coordinates are driven directly rather than
// sweeping a whole raster, with hand-computed fill lengths and pixel colours.
module tb_screen_interface2;
  localparam int CH = 4, HPW = 8, CW = 11;
  localparam logic [2:0] C_FULL = 3'b010, C_LOW = 3'b100, C_BORDER = 3'b111, C_BG = 3'b001;
  localparam int MAX_UPD = CH * (HPW + 6 + 2) + 2;  // 66 cycles

  logic              clk = 1'b0;
  logic              rst;
  logic [CW-1:0]     c1, c2;
  logic [CH*HPW-1:0] hp, maxhp;
  logic [2:0]        rgb;
  logic              busy, update_done;

  int n_checks = 0;
  int n_fail   = 0;

  screen_interface2 dut (
    .clk(clk), .rst(rst), .c1(c1), .c2(c2), .hp(hp), .maxhp(maxhp),
    .rgb(rgb), .busy(busy), .update_done(update_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input int h, input int m);
    hp[k*HPW +: HPW]    = HPW'(h);
    maxhp[k*HPW +: HPW] = HPW'(m);
  endtask

  task automatic park();
    c1 = 11'd700;
    c2 = 11'd10;
  endtask

  task automatic pix(input string tag, input int x, input int y, input int exp);
    @(negedge clk);
    c1 = CW'(x);
    c2 = CW'(y);
    @(posedge clk);
    #1;
    chk(tag, int'(rgb), exp);
    @(negedge clk);
    park();
  endtask

  task automatic trigger();
    @(negedge clk);
    c1 = '0;
    c2 = 11'd480;
    @(posedge clk);
    @(negedge clk);
    park();
  endtask

  task automatic run_update(input string tag);
    int cnt;
    bit saw;
    cnt = 1;
    saw = 0;
    trigger();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (update_done) begin
        saw = 1;
        break;
      end
    end
    chk({tag, " done_seen"}, int'(saw), 1);
    chk({tag, " update_time"}, int'(cnt <= MAX_UPD), 1);
    chk({tag, " busy_low_at_done"}, int'(busy), 0);
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_one_cycle"}, int'(update_done), 0);
  endtask

  initial begin
    rst = 1'b1;
    park();
    for (int k = 0; k < CH; k++) set_ch(k, 100, 100);
    repeat (3) @(posedge clk);
    #1;
    chk("reset rgb", int'(rgb), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset update_done", int'(update_done), 0);
    @(negedge clk);
    rst = 1'b0;

    // before the first commit every bar interior is background
    for (int k = 0; k < CH; k++) begin
      pix("pre-commit interior left", 17, 17 + k*12, C_BG);
      pix("pre-commit interior right", 80, 20 + k*12, C_BG);
    end
    pix("outside bars", 5, 5, 0);

    run_update("full");
    pix("full bar0 off63", 80, 17, C_FULL);
    pix("full bar3 off63", 80, 53, C_FULL);

    // mixed fills and edge values
    set_ch(0, 50, 100);
    set_ch(1, 10, 100);
    set_ch(2, 5, 0);
    set_ch(3, 200, 100);
    run_update("mixed");
    pix("bar0 off31", 48, 20, C_FULL);
    pix("bar0 off32", 49, 20, C_BG);
    pix("bar0 left border", 16, 19, C_BORDER);
    pix("bar0 right border", 81, 19, C_BORDER);
    pix("bar0 top border", 40, 16, C_BORDER);
    pix("bar1 off5 low", 22, 30, C_LOW);
    pix("bar1 off6", 23, 30, C_BG);
    pix("bar2 zero maxhp", 17, 42, C_BG);
    pix("bar3 clamped off63", 80, 54, C_FULL);
    pix("bar3 bottom border", 50, 59, C_BORDER);
    pix("below bar3", 50, 60, 0);
    pix("gap row", 40, 25, 0);
    pix("left of border", 15, 20, 0);
    pix("right of border", 82, 20, 0);

    set_ch(1, 25, 100);
    run_update("quarter");
    pix("bar1 off15 full colour", 32, 30, C_FULL);
    pix("bar1 off16", 33, 30, C_BG);

    // a mid-frame hp change stays invisible until the next commit
    set_ch(0, 100, 100);
    run_update("refill");
    pix("bar0 refilled", 80, 20, C_FULL);
    @(negedge clk);
    c2 = 11'd200;
    set_ch(0, 0, 100);
    pix("bar0 after midframe change", 80, 20, C_FULL);
    pix("bar0 off0 after midframe change", 17, 20, C_FULL);
    run_update("drain");
    pix("bar0 drained off0", 17, 20, C_BG);
    pix("bar0 drained off63", 80, 20, C_BG);
    pix("bar3 still full", 80, 54, C_FULL);

    // reset in the middle of channel 2's division
    for (int k = 0; k < CH; k++) set_ch(k, 100, 100);
    trigger();
    repeat (38) @(posedge clk);
    #1;
    chk("busy during update", int'(busy), 1);
    trigger();
    repeat (2) @(posedge clk);
    #1;
    chk("busy after ignored trigger", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    c1 = 11'd17;
    c2 = 11'd30;
    @(posedge clk);
    #1;
    chk("midupdate reset busy", int'(busy), 0);
    chk("midupdate reset rgb", int'(rgb), 0);
    @(negedge clk);
    rst = 1'b0;
    park();
    pix("bar1 empty after reset", 17, 30, C_BG);
    pix("bar3 empty after reset", 80, 54, C_BG);
    run_update("after reset");
    pix("bar2 full after reset", 80, 42, C_FULL);
    pix("bar0 full after reset", 17, 20, C_FULL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
